// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} tx_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 32;
  localparam int DATA_BITS            = 8;
  localparam int BYTES_PER_WORD       = 4;

endpackage

// File: rtl/uart_byte_tx.sv
// Serializes one byte as an 8N1 frame; owns start/data/stop bit timing.
// A new start is accepted in IDLE or in the last clock of a stop bit, so frames can run back to back.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] byte_in,
  input  logic       start,
  output logic       tx,
  output logic       byte_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(CLKS_PER_BIT - 2);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_t     state;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    data;

  // byte_done is raised one clock early so it lands on the final stop-bit clock
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      data      <= '0;
      tx        <= 1'b1;
      byte_done <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            data    <= byte_in;
            clk_cnt <= '0;
            state   <= START;
            tx      <= 1'b0;
          end
        end
        START: begin
          if (clk_cnt == LAST) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
            state   <= DATA;
            tx      <= data[0];
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (clk_cnt == LAST) begin
            clk_cnt <= '0;
            if (bit_cnt == LAST_BIT) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              data    <= {1'b0, data[7:1]};
              tx      <= data[1];
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          if (clk_cnt == PRE_LAST) begin
            byte_done <= 1'b1;
          end
          if (clk_cnt == LAST) begin
            clk_cnt <= '0;
            if (start) begin
              data  <= byte_in;
              state <= START;
              tx    <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_word_tx.sv
// Sends one 32-bit word per valid/ready handshake as four 8N1 frames, LSB byte first.
// Owns the handshake, byte sequencing, inter-byte gap and word_done.
module uart_word_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int GAP_CLKS     = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] word_in,
  input  logic        word_valid,
  output logic        word_ready,
  output logic        tx,
  output logic        busy,
  output logic        word_done
);

  localparam int GW = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
  localparam bit   HAS_GAP  = (GAP_CLKS > 0);
  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  tx_state_t     state;
  logic [31:0]   shift;
  logic [1:0]    byte_cnt;
  logic [GW-1:0] gap_cnt;
  logic          accept;
  logic          last_byte;
  logic          byte_start;
  logic [7:0]    byte_data;
  logic          byte_done;

  // The first byte comes straight from word_in so the start bit appears the cycle after acceptance
  always_comb begin
    accept     = word_valid && word_ready;
    last_byte  = (byte_cnt == LAST_BYTE);
    byte_start = 1'b0;
    byte_data  = shift[7:0];
    case (state)
      IDLE: begin
        byte_start = accept;
        byte_data  = word_in[7:0];
      end
      DATA:    byte_start = byte_done && !last_byte && !HAS_GAP;
      GAP:     byte_start = (gap_cnt == GAP_LAST);
      default: byte_start = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      shift      <= '0;
      byte_cnt   <= '0;
      gap_cnt    <= '0;
      word_ready <= 1'b1;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shift      <= {8'h00, word_in[31:8]};
            byte_cnt   <= '0;
            state      <= DATA;
            word_ready <= 1'b0;
            busy       <= 1'b1;
          end
        end
        DATA: begin
          if (byte_done) begin
            byte_cnt <= byte_cnt + 2'd1;
            if (last_byte) begin
              state      <= IDLE;
              word_ready <= 1'b1;
              busy       <= 1'b0;
            end else if (HAS_GAP) begin
              state   <= GAP;
              gap_cnt <= '0;
            end else begin
              shift <= {8'h00, shift[31:8]};
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state   <= DATA;
            gap_cnt <= '0;
            shift   <= {8'h00, shift[31:8]};
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          word_ready <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

  assign word_done = byte_done && last_byte && (state == DATA);

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk      (clk),
    .reset_n  (reset_n),
    .byte_in  (byte_data),
    .start    (byte_start),
    .tx       (tx),
    .byte_done(byte_done)
  );

endmodule

// File: tb/tb_uart_word_tx.sv
// Self-checking bench for uart_word_tx: compares the serial waveform against a per-clock model
// built from the 8N1 framing rules, for a gapless and a gapped instance.
module tb_uart_word_tx;

  localparam int CPB = 32;
  localparam int GAP = 5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] word_in_d = '0, word_in_g = '0;
  logic        valid_d = 1'b0, valid_g = 1'b0;
  logic        ready_d, ready_g, tx_d, tx_g, busy_d, busy_g, done_d, done_g;

  logic sel = 1'b0;
  logic tx_s, ready_s, busy_s, done_s;

  int vectors = 0;
  int miscompares = 0;
  bit exp_wave[$];

  always #5 clk = ~clk;

  uart_word_tx #(.CLKS_PER_BIT(CPB), .GAP_CLKS(0)) dut (
    .clk(clk), .reset_n(reset_n), .word_in(word_in_d), .word_valid(valid_d),
    .word_ready(ready_d), .tx(tx_d), .busy(busy_d), .word_done(done_d)
  );

  uart_word_tx #(.CLKS_PER_BIT(CPB), .GAP_CLKS(GAP)) dut_gap (
    .clk(clk), .reset_n(reset_n), .word_in(word_in_g), .word_valid(valid_g),
    .word_ready(ready_g), .tx(tx_g), .busy(busy_g), .word_done(done_g)
  );

  always_comb begin
    tx_s    = sel ? tx_g    : tx_d;
    ready_s = sel ? ready_g : ready_d;
    busy_s  = sel ? busy_g  : busy_d;
    done_s  = sel ? done_g  : done_d;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] w, input logic v, input logic use_gap);
    if (use_gap) begin
      word_in_g = w;
      valid_g   = v;
    end else begin
      word_in_d = w;
      valid_d   = v;
    end
  endtask

  // Expected tx level for every clock of a word, starting the cycle after acceptance
  function automatic void buildWave(input logic [31:0] w, input int gap);
    exp_wave.delete();
    for (int b = 0; b < 4; b++) begin
      if (b > 0) for (int g = 0; g < gap; g++) exp_wave.push_back(1'b1);
      for (int c = 0; c < CPB; c++) exp_wave.push_back(1'b0);
      for (int i = 0; i < 8; i++)
        for (int c = 0; c < CPB; c++) exp_wave.push_back(w[8*b+i]);
      for (int c = 0; c < CPB; c++) exp_wave.push_back(1'b1);
    end
  endfunction

  task automatic runWord(input logic [31:0] w, input logic use_gap, input logic hold,
                         input logic [31:0] next_w);
    int gap;
    int total;
    int wave_err = 0, done_cnt = 0, done_at = 0, busy_cnt = 0, ready_lo = 0;
    bit got_wave[$];
    logic [31:0] decoded;
    gap = use_gap ? GAP : 0;
    buildWave(w, gap);
    total = exp_wave.size();
    sel = use_gap;
    checkOutput("ready_before", {31'd0, ready_s}, 32'd1);
    applyStimulus(w, 1'b1, use_gap);
    @(posedge clk);
    @(negedge clk);
    if (hold) applyStimulus(next_w, 1'b1, use_gap);
    else      applyStimulus($urandom, 1'b0, use_gap);
    for (int k = 0; k < total; k++) begin
      if (k > 0) @(negedge clk);
      got_wave.push_back(tx_s);
      if (tx_s !== exp_wave[k]) wave_err++;
      if (done_s === 1'b1) begin
        done_cnt++;
        if (done_at == 0) done_at = k + 1;
      end
      if (busy_s === 1'b1) busy_cnt++;
      if (ready_s === 1'b0) ready_lo++;
    end
    decoded = '0;
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 8; i++)
        decoded[8*b+i] = got_wave[b*(10*CPB+gap) + (i+1)*CPB + CPB/2 - 1];
    checkOutput("tx_wave_err", wave_err, 0);
    checkOutput("decoded_word", decoded, w);
    checkOutput("done_clock", done_at, total);
    checkOutput("done_count", done_cnt, 1);
    checkOutput("busy_clocks", busy_cnt, total);
    checkOutput("ready_low_clocks", ready_lo, total);
    @(negedge clk);
    checkOutput("idle_after_word", {28'd0, tx_s, ready_s, busy_s, done_s}, 32'hC);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int bad;
    logic [31:0] w;

    repeat (3) @(negedge clk);
    checkOutput("reset_outs", {28'd0, tx_d, ready_d, busy_d, done_d}, 32'hC);
    checkOutput("reset_outs_gap", {28'd0, tx_g, ready_g, busy_g, done_g}, 32'hC);
    reset_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (tx_d !== 1'b1 || ready_d !== 1'b1 || busy_d !== 1'b0) bad++;
    end
    checkOutput("idle_after_reset", bad, 0);

    runWord(32'hA5C3_0F81, 1'b0, 1'b0, '0);
    runWord(32'hDEAD_BEEF, 1'b0, 1'b0, '0);
    runWord(32'h0000_0000, 1'b0, 1'b1, 32'hFFFF_FFFF);
    runWord(32'hFFFF_FFFF, 1'b0, 1'b0, '0);
    repeat (3) runWord($urandom, 1'b0, 1'b0, '0);

    runWord(32'h0102_0304, 1'b1, 1'b0, '0);
    repeat (2) runWord($urandom, 1'b1, 1'b0, '0);

    // Reset during the second byte's data bits, where the line is driven low
    sel = 1'b0;
    w = $urandom & 32'hFFFF_00FF;
    applyStimulus(w, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(w, 1'b0, 1'b0);
    repeat (399) @(negedge clk);
    checkOutput("tx_before_reset", {31'd0, tx_s}, 32'd0);
    reset_n = 1'b0;
    #1;
    checkOutput("reset_mid_word", {28'd0, tx_s, ready_s, busy_s, done_s}, 32'hC);
    @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 1400; k++) begin
      @(negedge clk);
      if (done_s !== 1'b0 || tx_s !== 1'b1 || ready_s !== 1'b1) bad++;
    end
    checkOutput("quiet_after_reset", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_word_tx.md
# uart_word_tx

Transmit-side counterpart of the UART byte receiver. Accepts one 32-bit word per valid/ready handshake and serializes it on `tx` as four 8N1 UART frames, least-significant byte first, LSB first within each byte. Bit period matches the receiver: 32 clocks per bit by default. It sits between the word-producing logic and the board TX pin.

## Interface
- `CLKS_PER_BIT`, default 32: clocks per serial bit; must be ≥ 2.
- `GAP_CLKS`, default 0: idle-high clocks inserted between consecutive bytes of one word.
- `clk`  in  1  rising-edge system clock.
- `reset_n`  in  1  asynchronous, active-low reset. The design has one clock; reset is asynchronous and active-low.
- `word_in`  in  32  word to send; sampled only at handshake.
- `word_valid`  in  1  producer has a word.
- `word_ready`  out  1  block can accept a word; high only in IDLE.
- `tx`  out  1  serial line; idle high; driven from a flop.
- `busy`  out  1  high from the cycle after acceptance through the final stop bit.
- `word_done`  out  1  one-cycle pulse in the last clock of the 4th stop bit.

## Operation
- Handshake: transfer occurs on a rising edge where `word_valid && word_ready`. `word_in` is latched into a 32-bit shift register. `word_ready` drops on the next cycle. `word_valid` without `word_ready` has no effect.
- Frame per byte:
  - start bit: 0.
  - `data[0]`..`data[7]`.
  - stop bit: 1.
  - Every bit is held for exactly `CLKS_PER_BIT` clocks.
- Byte order: `word_in[7:0]`, `[15:8]`, `[23:16]`, `[31:24]`.
- FSM states:
  - IDLE: `tx`=1, `word_ready`=1. On handshake → START.
  - START: `tx`=0. After `CLKS_PER_BIT` clocks → DATA.
  - DATA: `tx`=current bit. The bit counter runs 0..7. After bit 7's period → STOP.
  - STOP: `tx`=1. At end of period:
    - If bytes sent < 4 and `GAP_CLKS`>0 → GAP.
    - If bytes sent < 4 and `GAP_CLKS`=0 → START.
    - After the 4th byte → IDLE with `word_done` pulse.
  - GAP: `tx`=1 for `GAP_CLKS` clocks → START.
- Counter widths:
  - Clock counter: `$clog2(CLKS_PER_BIT)` bits, counts 0..`CLKS_PER_BIT`-1, then wraps to 0.
  - Bit counter: 3 bits.
  - Byte counter: 2 bits; its wrap from 3 to 0 marks word end.
- Data is not re-sampled mid-word. Changing `word_in` after the handshake has no effect.

## Timing
- Reset values (asynchronous, immediate on `reset_n`=0):
  - `tx`=1, `word_ready`=1, `busy`=0, `word_done`=0.
  - State IDLE, all counters 0.
- Reset mid-frame: the frame is aborted immediately and `tx` returns high. No `word_done` pulse is produced. After release the block is in IDLE.
- Handshake at edge N:
  - Start bit appears on `tx` from cycle N+1.
  - `busy`=1 and `word_ready`=0 from cycle N+1.
- Word duration: 40·`CLKS_PER_BIT` + 3·`GAP_CLKS` clocks, from cycle N+1. With defaults this is 1280 clocks.
- `word_done` is high in the last clock of the final stop bit. In the next cycle `busy`=0 and `word_ready`=1.
- Back-to-back words (`word_valid` held high): accepted in the first IDLE cycle. This gives exactly one extra idle-high clock between words' stop and start bits.
- With `GAP_CLKS`=0, bytes within a word are contiguous: a stop bit is followed directly by the next start bit.

## Structure
- Shared package `uart_pkg`:
  - `tx_state_t` enum (IDLE, START, DATA, STOP, GAP).
  - `DEFAULT_CLKS_PER_BIT`=32.
  - `DATA_BITS`=8, `BYTES_PER_WORD`=4.
- One natural sub-module: `uart_byte_tx`.
  - Ports: `clk`, `reset_n`, `byte_in[7:0]`, `start`, `tx`, `byte_done`.
  - Owns the START/DATA/STOP bit timing.
- `uart_word_tx` owns:
  - the word handshake;
  - the byte counter and 32-bit shift register;
  - GAP timing;
  - `word_done`.

## Test plan
- Reset: hold `reset_n`=0 → `tx`=1, `word_ready`=1, `busy`=0, `word_done`=0. Deassert with `word_valid`=0 → `tx` stays 1 for 100 clocks.
- Single word: `word_in`=32'hA5C3_0F81, defaults. Sample `tx` at mid-bit (clock 16 of each 32-clock period). Decoded bytes must be 8'h81, 8'h0F, 8'hC3, 8'hA5, each with start=0 and stop=1. `word_done` pulses exactly at clock 1280 after acceptance.
- Loopback: drive `tx` into the existing byte receiver, with both blocks at 32 clocks per bit. Send 32'hDEAD_BEEF → `byte_end` fires 4 times with bytes EF, BE, AD, DE.
- Back-to-back: hold `word_valid`=1 with 32'h0000_0000 then 32'hFFFF_FFFF. The second start bit follows the first word's final stop bit after exactly one idle clock.
- Gap: `GAP_CLKS`=5, word 32'h0102_0304 → `tx` is high for 32+5 clocks between each start bit and the previous byte's last data bit. Total duration is 1295 clocks.
- Reset mid-word: assert `reset_n`=0 during the 2nd byte's DATA state → `tx`=1 in the same cycle. After release `word_ready`=1 and no `word_done` appears.
